avgp_3x3_window: RTL and testbench
==================================

# avgp_3x3_window

Streaming 3x3 window generator that feeds `avgp_3x3_core`. It accepts one raster-order pixel per valid cycle and buffers the two previous image rows. For every input position where a full 3x3 neighbourhood exists (valid mode, stride 1, no padding), it presents the nine pixels of that neighbourhood in parallel. Outputs connect 1:1 to the core's `pxl_in_00..08` / `valid_in`.

## Interface
- `DATA_WIDTH`, 32, pixel width in bits; opaque data, never interpreted.
- `IMAGE_WIDTH`, 33, pixels per row; legal range ≥ 3.
- `IMAGE_HEIGHT`, 33, rows per frame; legal range ≥ 3.
- `clk`  input  1  clock, all logic on rising edge.
- `reset`  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `valid_in`  input  1  `pxl_in` carries the next raster pixel this cycle.
- `pxl_in`  input  DATA_WIDTH  input pixel.
- `pxl_out_00`..`pxl_out_08`  output  DATA_WIDTH each  window pixels, row-major: 00–02 are row r-2, 03–05 are row r-1, 06–08 are row r; within a row, columns c-2, c-1, c.
- `valid_out`  output  1  window valid, one-cycle pulse per window.
- `frame_done`  output  1  one-cycle pulse coincident with the last window of a frame.

## Operation
- Storage is a shift chain of 2*IMAGE_WIDTH+3 entries, advanced only on cycles with `valid_in`=1.
  - Taps give column c-2..c of rows r-2, r-1 and r, where (r,c) is the pixel being accepted.
  - Implementation may use shift registers or RAM plus column registers, provided the output timing below holds.
- Column counter `col`, range 0..IMAGE_WIDTH-1, and row counter `row`, range 0..IMAGE_HEIGHT-1.
  - Both index the pixel accepted this cycle.
  - `col` increments on each accepted pixel and wraps to 0 after IMAGE_WIDTH-1; on that wrap `row` increments.
  - `row` wraps to 0 after the last pixel of the frame, so the next frame starts with no gap and no reset.
- Window emitted when an accepted pixel has `row`≥2 and `col`≥2. Result is (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2) windows per frame.
- Pixels in columns 0–1 never produce a window, so no window spans a row boundary.
- `frame_done` asserts with the window of pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1).
- Stale data from the previous frame sits in the row buffers but is never emitted, because windows are gated by `row`≥2.
- No backpressure: the downstream core accepts every window.
- Counter widths are `$clog2` of the respective dimension. No arithmetic is applied to pixel data.

## Timing
- Latency is 1 cycle. Pixel (r,c) accepted at edge k produces `valid_out`=1 and its window on `pxl_out_*` in the cycle after edge k.
- All outputs are registered.
- `valid_out` and `frame_done` are low in every cycle not following a qualifying accept.
- `pxl_out_*` hold their last value while `valid_out`=0.
- Bubbles (`valid_in`=0): counters and buffers freeze. Windows are bit-identical to a bubble-free stream.
- Back-to-back `valid_in`=1 sustains one window per cycle inside a row. Each row gives 2 idle output slots at columns 0–1.
- Reset asserted (low), async:
  - `valid_out`, `frame_done` = 0;
  - all `pxl_out_*` = 0;
  - counters = 0;
  - buffer contents cleared to 0.
- Reset mid-frame abandons the frame. The first pixel after release is treated as (0,0).
- Release is synchronised by the integrator; the block samples `valid_in` from the first rising edge with `reset`=1.

## Test plan
- **4x4 frame, no bubbles.** IMAGE_WIDTH=IMAGE_HEIGHT=4, pixels 0..15 → exactly 4 windows.
  - First window, one cycle after pixel 10: (0,1,2,4,5,6,8,9,10).
  - Then (1,2,3,5,6,7,9,10,11), (4,5,6,8,9,10,12,13,14), (5,6,7,9,10,11,13,14,15).
  - `frame_done` only with the last window.
- **Random bubbles.** Same stream with `valid_in` randomly low about 40% of cycles → same 4 windows in the same order. Each `valid_out` is exactly 1 cycle after its pixel's accept. Outputs hold between windows.
- **Back-to-back frames.** Frame A pixels 0..15, then frame B pixels 100..115, no gap → B's first window is (100,101,102,104,105,106,108,109,110). No window mixes A and B data.
- **Reset mid-frame.** Drop `reset` after pixel 9 of frame A:
  - all outputs read 0 while low;
  - after release, stream 16 pixels 200..215 → first window (200,201,202,204,205,206,208,209,210).
- **Default parameters (33x33), random data.**
  - 961 windows, `frame_done` count 1.
  - Every window matches a software 3x3 valid-mode extractor.
  - Feeding the outputs into `avgp_3x3_core` gives the reference 3x3 means.

Source files
------------

// File: rtl/avgp_3x3_window.sv
// avgp_3x3_window
// Streaming 3x3 window generator for a raster-order pixel stream. Two image
// rows plus two pixels are kept in a shift chain. For every accepted pixel
// (r,c) with r>=2 and c>=2 the nine neighbourhood pixels are presented in
// parallel one cycle later, together with a valid pulse. The last window of
// a frame also pulses frame_done. Pixel data is passed through unchanged.
module avgp_3x3_window #(
    parameter int DATA_WIDTH   = 32,
    parameter int IMAGE_WIDTH  = 33,
    parameter int IMAGE_HEIGHT = 33
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out_00,
    output logic [DATA_WIDTH-1:0] pxl_out_01,
    output logic [DATA_WIDTH-1:0] pxl_out_02,
    output logic [DATA_WIDTH-1:0] pxl_out_03,
    output logic [DATA_WIDTH-1:0] pxl_out_04,
    output logic [DATA_WIDTH-1:0] pxl_out_05,
    output logic [DATA_WIDTH-1:0] pxl_out_06,
    output logic [DATA_WIDTH-1:0] pxl_out_07,
    output logic [DATA_WIDTH-1:0] pxl_out_08,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int CW    = $clog2(IMAGE_WIDTH);
    localparam int RW    = $clog2(IMAGE_HEIGHT);
    // Previous pixels needed: two full rows plus two columns of row r-2.
    // Together with pxl_in this forms the 2*IMAGE_WIDTH+3 entry window chain.
    localparam int DEPTH = 2 * IMAGE_WIDTH + 2;

    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // chain[0] is the pixel accepted just before the current one.
    logic [DATA_WIDTH-1:0] chain [DEPTH];
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  col_last;
    logic                  row_last;
    logic                  emit;
    logic [DATA_WIDTH-1:0] win   [9];
    logic [DATA_WIDTH-1:0] win_q [9];

    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign emit     = valid_in && (col >= COL_TWO) && (row >= ROW_TWO);

    // Raster position of the pixel being accepted this cycle.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Row buffer: shifts one position per accepted pixel, frozen on bubbles.
    // NOTE: the chain is cleared on reset so no pre-reset data can ever be
    // observed; this costs reset fan-out on every buffer flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) chain[i] <= '0;
        end else if (valid_in) begin
            chain[0] <= pxl_in;
            for (int i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
        end
    end

    // Window taps for pixel (r,c): row r-2 sits 2*IMAGE_WIDTH back, row r-1
    // IMAGE_WIDTH back, row r is pxl_in and the two most recent pixels.
    always_comb begin
        win[0] = chain[2*IMAGE_WIDTH+1];
        win[1] = chain[2*IMAGE_WIDTH];
        win[2] = chain[2*IMAGE_WIDTH-1];
        win[3] = chain[IMAGE_WIDTH+1];
        win[4] = chain[IMAGE_WIDTH];
        win[5] = chain[IMAGE_WIDTH-1];
        win[6] = chain[1];
        win[7] = chain[0];
        win[8] = pxl_in;
    end

    // Registered outputs: the window loads only on an emitting accept and
    // otherwise holds; the strobes are single-cycle pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            valid_out  <= emit;
            frame_done <= emit && col_last && row_last;
            if (emit) begin
                for (int i = 0; i < 9; i++) win_q[i] <= win[i];
            end
        end
    end

    assign pxl_out_00 = win_q[0];
    assign pxl_out_01 = win_q[1];
    assign pxl_out_02 = win_q[2];
    assign pxl_out_03 = win_q[3];
    assign pxl_out_04 = win_q[4];
    assign pxl_out_05 = win_q[5];
    assign pxl_out_06 = win_q[6];
    assign pxl_out_07 = win_q[7];
    assign pxl_out_08 = win_q[8];

endmodule

// File: tb/tb_avgp_3x3_window.sv
// Testbench for avgp_3x3_window: a 4x4 instance for the directed scenarios and
// a default 33x33 instance for the long random frame. Expected windows come
// from a per-instance image array indexed by (row, column).
module tb_avgp_3x3_window;

    logic        clk = 1'b0;
    logic        reset;
    logic        vin   [2];
    logic [31:0] pin   [2];
    logic        vout  [2];
    logic        fdone [2];
    logic [31:0] o     [2][9];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, index 0 = 4x4 instance, 1 = 33x33 instance.
    int          m_w [2];
    int          m_h [2];
    int          m_n [2];
    logic [31:0] m_img [2][33][33];
    logic        m_ev [2];
    logic        m_ed [2];
    logic [31:0] m_ew [2][9];

    always #5 clk = ~clk;

    avgp_3x3_window #(.DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)) dut_s (
        .clk(clk), .reset(reset), .valid_in(vin[0]), .pxl_in(pin[0]),
        .pxl_out_00(o[0][0]), .pxl_out_01(o[0][1]), .pxl_out_02(o[0][2]),
        .pxl_out_03(o[0][3]), .pxl_out_04(o[0][4]), .pxl_out_05(o[0][5]),
        .pxl_out_06(o[0][6]), .pxl_out_07(o[0][7]), .pxl_out_08(o[0][8]),
        .valid_out(vout[0]), .frame_done(fdone[0])
    );

    avgp_3x3_window dut_l (
        .clk(clk), .reset(reset), .valid_in(vin[1]), .pxl_in(pin[1]),
        .pxl_out_00(o[1][0]), .pxl_out_01(o[1][1]), .pxl_out_02(o[1][2]),
        .pxl_out_03(o[1][3]), .pxl_out_04(o[1][4]), .pxl_out_05(o[1][5]),
        .pxl_out_06(o[1][6]), .pxl_out_07(o[1][7]), .pxl_out_08(o[1][8]),
        .valid_out(vout[1]), .frame_done(fdone[1])
    );

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_n[s]  = 0;
            m_ev[s] = 1'b0;
            m_ed[s] = 1'b0;
            for (int i = 0; i < 9; i++) m_ew[s][i] = '0;
        end
    endtask

    // Called at a falling edge: drives one cycle into instance sel, updates
    // the model, and returns at the next falling edge when outputs are due.
    task automatic drive(input int sel, input logic v, input logic [31:0] p);
        int r, c;
        for (int s = 0; s < 2; s++) begin
            vin[s]  = (s == sel) ? v : 1'b0;
            pin[s]  = p;
            m_ev[s] = 1'b0;
            m_ed[s] = 1'b0;
        end
        if (v) begin
            r = m_n[sel] / m_w[sel];
            c = m_n[sel] % m_w[sel];
            m_img[sel][r][c] = p;
            if (r >= 2 && c >= 2) begin
                m_ev[sel] = 1'b1;
                m_ed[sel] = (r == m_h[sel] - 1) && (c == m_w[sel] - 1);
                for (int i = 0; i < 9; i++)
                    m_ew[sel][i] = m_img[sel][r - 2 + i / 3][c - 2 + i % 3];
            end
            m_n[sel] = (m_n[sel] + 1) % (m_w[sel] * m_h[sel]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (vout[s] !== 1'b0 || fdone[s] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_flags[%0d]: valid=%b done=%b expected 0 0", s, vout[s], fdone[s]);
            end
            for (int i = 0; i < 9; i++) begin
                n_checks++;
                if (o[s][i] !== 32'd0) begin
                    n_errors++;
                    $display("FAIL reset_pxl[%0d][%0d]: got %0d expected 0", s, i, o[s][i]);
                end
            end
        end
    endtask

    // 4x4 frame 0..15 with no bubbles; first window also checked against a constant.
    task automatic test_4x4_no_bubbles();
        int wins = 0;
        for (int p = 0; p < 16; p++) begin
            drive(0, 1'b1, p);
            n_checks++;
            if (vout[0] !== m_ev[0] || fdone[0] !== m_ed[0]) begin
                n_errors++;
                $display("FAIL nobub_flags pix=%0d: valid=%b done=%b expected %b %b", p, vout[0], fdone[0], m_ev[0], m_ed[0]);
            end
            for (int i = 0; i < 9; i++) begin
                n_checks++;
                if (o[0][i] !== m_ew[0][i]) begin
                    n_errors++;
                    $display("FAIL nobub_pxl pix=%0d idx=%0d: got %0d expected %0d", p, i, o[0][i], m_ew[0][i]);
                end
            end
            if (vout[0] === 1'b1) wins++;
            if (p == 10) begin
                for (int i = 0; i < 9; i++) begin
                    n_checks++;
                    if (o[0][i] !== 32'((i / 3) * 4 + i % 3)) begin
                        n_errors++;
                        $display("FAIL first_window idx=%0d: got %0d expected %0d", i, o[0][i], (i / 3) * 4 + i % 3);
                    end
                end
            end
        end
        n_checks++;
        if (wins != 4) begin
            n_errors++;
            $display("FAIL nobub_count: got %0d windows expected 4", wins);
        end
    endtask

    // Same stream with roughly 40% bubbles carrying junk data.
    task automatic test_random_bubbles();
        int idx = 0;
        int wins = 0;
        for (int cyc = 0; cyc < 300 && idx < 16; cyc++) begin
            if ($urandom_range(0, 99) < 40) drive(0, 1'b0, $urandom);
            else begin
                drive(0, 1'b1, idx);
                idx++;
            end
            n_checks++;
            if (vout[0] !== m_ev[0] || fdone[0] !== m_ed[0]) begin
                n_errors++;
                $display("FAIL bub_flags cyc=%0d: valid=%b done=%b expected %b %b", cyc, vout[0], fdone[0], m_ev[0], m_ed[0]);
            end
            for (int i = 0; i < 9; i++) begin
                n_checks++;
                if (o[0][i] !== m_ew[0][i]) begin
                    n_errors++;
                    $display("FAIL bub_pxl cyc=%0d idx=%0d: got %0d expected %0d", cyc, i, o[0][i], m_ew[0][i]);
                end
            end
            if (vout[0] === 1'b1) wins++;
        end
        n_checks++;
        if (idx != 16 || wins != 4) begin
            n_errors++;
            $display("FAIL bub_count: pixels=%0d windows=%0d expected 16 and 4", idx, wins);
        end
    endtask

    // Frame A 0..15 directly followed by frame B 100..115.
    task automatic test_back_to_back();
        bit seen_b = 0;
        int done_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            drive(0, 1'b1, (k < 16) ? k : 100 + k - 16);
            n_checks++;
            if (vout[0] !== m_ev[0] || fdone[0] !== m_ed[0]) begin
                n_errors++;
                $display("FAIL b2b_flags k=%0d: valid=%b done=%b expected %b %b", k, vout[0], fdone[0], m_ev[0], m_ed[0]);
            end
            for (int i = 0; i < 9; i++) begin
                n_checks++;
                if (o[0][i] !== m_ew[0][i]) begin
                    n_errors++;
                    $display("FAIL b2b_pxl k=%0d idx=%0d: got %0d expected %0d", k, i, o[0][i], m_ew[0][i]);
                end
            end
            if (fdone[0] === 1'b1) done_cnt++;
            if (k >= 16 && vout[0] === 1'b1 && !seen_b) begin
                seen_b = 1;
                for (int i = 0; i < 9; i++) begin
                    n_checks++;
                    if (o[0][i] !== 32'(100 + (i / 3) * 4 + i % 3)) begin
                        n_errors++;
                        $display("FAIL b2b_first idx=%0d: got %0d expected %0d", i, o[0][i], 100 + (i / 3) * 4 + i % 3);
                    end
                end
            end
        end
        n_checks++;
        if (!seen_b || done_cnt != 2) begin
            n_errors++;
            $display("FAIL b2b_frames: seen_b=%0d frame_done=%0d expected 1 and 2", seen_b, done_cnt);
        end
    endtask

    // Reset after pixel 9, then a fresh frame 200..215.
    task automatic test_reset_mid_frame();
        bit seen = 0;
        for (int p = 0; p < 10; p++) drive(0, 1'b1, p);
        vin[0] = 1'b0;
        reset  = 1'b0;
        #1;
        model_reset();
        test_reset();
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b1;
        for (int p = 0; p < 16; p++) begin
            drive(0, 1'b1, 200 + p);
            n_checks++;
            if (vout[0] !== m_ev[0] || fdone[0] !== m_ed[0]) begin
                n_errors++;
                $display("FAIL rst_flags pix=%0d: valid=%b done=%b expected %b %b", p, vout[0], fdone[0], m_ev[0], m_ed[0]);
            end
            if (vout[0] === 1'b1 && !seen) begin
                seen = 1;
                n_checks++;
                if (p != 10) begin
                    n_errors++;
                    $display("FAIL rst_first_pos: got pixel %0d expected 10", p);
                end
                for (int i = 0; i < 9; i++) begin
                    n_checks++;
                    if (o[0][i] !== 32'(200 + (i / 3) * 4 + i % 3)) begin
                        n_errors++;
                        $display("FAIL rst_first idx=%0d: got %0d expected %0d", i, o[0][i], 200 + (i / 3) * 4 + i % 3);
                    end
                end
            end
        end
    endtask

    // Default 33x33 instance, random data, about 25% bubbles.
    task automatic test_default_random();
        int idx = 0;
        int wins = 0;
        int dones = 0;
        for (int cyc = 0; cyc < 4000 && idx < 33 * 33; cyc++) begin
            if ($urandom_range(0, 99) < 25) drive(1, 1'b0, $urandom);
            else begin
                drive(1, 1'b1, $urandom);
                idx++;
            end
            n_checks++;
            if (vout[1] !== m_ev[1] || fdone[1] !== m_ed[1]) begin
                n_errors++;
                $display("FAIL big_flags cyc=%0d: valid=%b done=%b expected %b %b", cyc, vout[1], fdone[1], m_ev[1], m_ed[1]);
            end
            for (int i = 0; i < 9; i++) begin
                n_checks++;
                if (o[1][i] !== m_ew[1][i]) begin
                    n_errors++;
                    $display("FAIL big_pxl cyc=%0d idx=%0d: got %h expected %h", cyc, i, o[1][i], m_ew[1][i]);
                end
            end
            if (vout[1] === 1'b1) wins++;
            if (fdone[1] === 1'b1) dones++;
        end
        n_checks++;
        if (idx != 33 * 33 || wins != 961 || dones != 1) begin
            n_errors++;
            $display("FAIL big_count: pixels=%0d windows=%0d frame_done=%0d expected 1089 961 1", idx, wins, dones);
        end
    endtask

    initial begin
        m_w[0] = 4;  m_h[0] = 4;
        m_w[1] = 33; m_h[1] = 33;
        model_reset();
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            vin[s] = 1'b0;
            pin[s] = '0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_4x4_no_bubbles();
        test_random_bubbles();
        test_back_to_back();
        test_reset_mid_frame();
        test_default_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
